sync_fifo: RTL and testbench

Single-clock first-in-first-out buffer: the queue-order counterpart of the team's stack (LIFO) block, sharing its push/pop port style so either can sit between a producer and consumer. Writes append at the tail and reads remove from the head, with registered full/empty flags, an occupancy count and sticky error flags. It is used wherever stream order must be preserved, for example UART byte buffering or command queues.

---
 rtl/sync_fifo_pkg.sv | 6 +
 rtl/fifo_mem.sv | 23 ++
 rtl/sync_fifo.sv | 68 ++++++
 tb/tb_sync_fifo.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - default geometry shared by the fifo and stack blocks
package sync_fifo_pkg;
  localparam int DEF_MEMWIDTH  = 4;
  localparam int DEF_ADDRWIDTH = 3;
  localparam int DEF_MEMDEPTH  = 2 ** DEF_ADDRWIDTH;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array, sync write and sync read, no reset
import sync_fifo_pkg::*;

module fifo_mem #(
  parameter int MEMWIDTH  = DEF_MEMWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [MEMWIDTH-1:0]  wr_data,
  input  logic                 rd_en,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [MEMWIDTH-1:0]  rd_data
);
  logic [MEMWIDTH-1:0] mem [2**ADDRWIDTH];

  // Same-address read and write returns the old word, which a full fifo relies on.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fifo with registered flags, occupancy and sticky errors
import sync_fifo_pkg::*;

module sync_fifo #(
  parameter int MEMWIDTH  = DEF_MEMWIDTH,
  parameter int MEMDEPTH  = DEF_MEMDEPTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrEn,
  input  logic                 rdEn,
  input  logic [MEMWIDTH-1:0]  dataIn,
  output logic [MEMWIDTH-1:0]  dataOut,
  output logic                 dataValid,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);
  logic [ADDRWIDTH:0]  wr_ptr, rd_ptr, count_nxt;
  logic                wr_acc, rd_acc, out_zero;
  logic [MEMWIDTH-1:0] mem_rd_data;

  assign rd_acc    = rdEn && !empty;
  assign wr_acc    = wrEn && (!full || rd_acc);
  assign count_nxt = count + (ADDRWIDTH+1)'(wr_acc) - (ADDRWIDTH+1)'(rd_acc);

  fifo_mem #(.MEMWIDTH(MEMWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && rst),
    .wr_addr (wr_ptr[ADDRWIDTH-1:0]),
    .wr_data (dataIn),
    .rd_en   (rd_acc && rst),
    .rd_addr (rd_ptr[ADDRWIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  // The array has no reset, so the output reads as zero until the first read after reset.
  assign dataOut = out_zero ? '0 : mem_rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      out_zero  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_zero <= 1'b0;
      end
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == (ADDRWIDTH+1)'(MEMDEPTH));
      dataValid <= rd_acc;
      if (wrEn && full && !rd_acc) overflow <= 1'b1;
      if (rdEn && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized and directed checks of sync_fifo against a queue model
module tb_sync_fifo;
  localparam int W = 4;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wrEn = 1'b0;
  logic         rdEn = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic [W-1:0] dataOut;
  logic         dataValid, full, empty, overflow, underflow;
  logic [A:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_out;
  bit           exp_val, exp_ovf, exp_unf;

  sync_fifo #(.MEMWIDTH(W), .MEMDEPTH(D), .ADDRWIDTH(A)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .dataIn(dataIn),
    .dataOut(dataOut), .dataValid(dataValid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    bit rd_ok, wr_ok;
    if (!r) begin
      q.delete();
      exp_out = '0;
      exp_val = 0;
      exp_ovf = 0;
      exp_unf = 0;
    end else begin
      rd_ok = rd && q.size() != 0;
      wr_ok = w && (q.size() < D || rd_ok);
      if (w && q.size() == D && !rd_ok) exp_ovf = 1;
      if (rd && q.size() == 0) exp_unf = 1;
      if (rd_ok) exp_out = q.pop_front();
      exp_val = rd_ok;
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("dataValid", 32'(dataValid), 32'(exp_val));
    chk("dataOut", 32'(dataOut), 32'(exp_out));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  // Drive on the falling edge, let the rising edge act, compare on the next falling edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    rst = r; wrEn = w; rdEn = rd; dataIn = d;
    @(posedge clk);
    model_step(r, w, rd, d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 4'h0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, 4'(i));
      chk("fill_not_empty", 32'(empty), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 1, 4'h0);
      chk("drain_order", 32'(dataOut), 32'(i));
      chk("drain_valid", 32'(dataValid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_no_ovf", 32'(overflow), 32'd0);
    chk("drain_no_unf", 32'(underflow), 32'd0);

    for (int i = 1; i <= 8; i++) cyc(1, 1, 0, 4'(i));
    cyc(1, 1, 0, 4'hF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 1, 4'h0);
      chk("ovf_order", 32'(dataOut), 32'(i));
    end

    cyc(1, 1, 1, 4'hA);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd1);
    chk("unf_no_valid", 32'(dataValid), 32'd0);
    cyc(1, 0, 1, 4'h0);
    chk("unf_read_a", 32'(dataOut), 32'hA);

    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 4'($urandom));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1, 4'($urandom));
      chk("wrap_count", 32'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 4'h0);

    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 4'($urandom));
    chk("pre_rst_full", 32'(full), 32'd1);
    cyc(0, 1, 1, 4'h5);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dataOut), 32'd0);
    chk("rst_valid", 32'(dataValid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    cyc(1, 1, 0, 4'h7);
    cyc(1, 0, 1, 4'h0);
    chk("post_rst_word", 32'(dataOut), 32'h7);

    for (int i = 0; i < 400; i++)
      cyc(($urandom % 64) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0, 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
